result_strobe_seq: RTL and testbench

//  Upstream of the result-display capture stage. Takes one 2x2 output tile from a
//  PE/systolic-array engine and replays it on a shared byte bus: out, c00..c11.

---
 rtl/result_strobe_seq.sv | 151 +++++++++++++++
 tb/tb_result_strobe_seq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/result_strobe_seq.sv
// Replays a captured 2x2 result tile on a shared byte bus with setup/pulse/hold framed capture strobes.
// One element every SETUP_CYC+PULSE_CYC+HOLD_CYC cycles; load is ignored while busy (ready = ~busy).
module result_strobe_seq #(
  parameter int DATA_W    = 8,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] in_c00,
  input  logic [DATA_W-1:0] in_c01,
  input  logic [DATA_W-1:0] in_c10,
  input  logic [DATA_W-1:0] in_c11,
  output logic              ready,
  output logic              busy,
  output logic [DATA_W-1:0] out,
  output logic              c00,
  output logic              c01,
  output logic              c10,
  output logic              c11,
  output logic              done
);

  localparam int MAX_PH = (SETUP_CYC > PULSE_CYC)
                        ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                        : ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
  localparam int CNT_W = (MAX_PH > 1) ? $clog2(MAX_PH) : 1;

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [1:0]                idx_q, idx_d;
  logic [1:0]                idx_nxt;
  logic [3:0][DATA_W-1:0]    tile_q, tile_d;
  logic [DATA_W-1:0]         out_q, out_d;
  logic [3:0]                strb_q, strb_d;
  logic                      busy_q, busy_d;
  logic                      ready_q, ready_d;
  logic                      done_q, done_d;

  assign idx_nxt = idx_q + 2'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    tile_d  = tile_q;
    out_d   = out_q;
    strb_d  = strb_q;
    busy_d  = busy_q;
    done_d  = done_q;

    case (state_q)
      S_IDLE: begin
        if (load) begin
          tile_d  = {in_c11, in_c10, in_c01, in_c00};
          out_d   = in_c00;
          idx_d   = 2'd0;
          cnt_d   = '0;
          state_d = S_SETUP;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = S_PULSE;
          strb_d  = 4'b0001 << idx_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          cnt_d   = '0;
          state_d = S_HOLD;
          strb_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d = '0;
          // out deliberately keeps the last element once the tile completes
          if (idx_q == 2'd3) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_nxt;
            out_d   = tile_q[idx_nxt];
            state_d = S_SETUP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = ~busy_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      tile_q  <= '0;
      out_q   <= '0;
      strb_q  <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tile_q  <= tile_d;
      out_q   <= out_d;
      strb_q  <= strb_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign out   = out_q;
  assign done  = done_q;
  assign c00   = strb_q[0];
  assign c01   = strb_q[1];
  assign c10   = strb_q[2];
  assign c11   = strb_q[3];

endmodule

// File: tb/tb_result_strobe_seq.sv
// Bench: two instances (default timing and 2/1/3 timing) driven with directed and random tiles,
// strobe/done events scoreboarded against a timeline model built from the phase lengths.
module tb_result_strobe_seq;

  localparam int MAXC = 2048;

  typedef struct {
    int         cyc;
    int         idx;
    logic [7:0] dat;
  } ev_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             ld [2];
  logic [3:0][7:0]  tl [2];

  wire [7:0] out0, out1;
  wire       rd0, rd1, bz0, bz1, dn0, dn1;
  wire       s00, s01, s02, s03, s10, s11, s12, s13;

  int  cyc = 0;
  int  tests = 0;
  int  fails = 0;
  int  bend [2];
  bit  eb [2][MAXC];
  bit  ed [2][MAXC];
  ev_t sq0[$], sq1[$];
  int  dq0[$], dq1[$];

  result_strobe_seq #(.DATA_W(8), .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)) dut (
    .clk(clk), .rst(rst), .load(ld[0]),
    .in_c00(tl[0][0]), .in_c01(tl[0][1]), .in_c10(tl[0][2]), .in_c11(tl[0][3]),
    .ready(rd0), .busy(bz0), .out(out0),
    .c00(s00), .c01(s01), .c10(s02), .c11(s03), .done(dn0)
  );

  result_strobe_seq #(.DATA_W(8), .SETUP_CYC(2), .PULSE_CYC(1), .HOLD_CYC(3)) dut2 (
    .clk(clk), .rst(rst), .load(ld[1]),
    .in_c00(tl[1][0]), .in_c01(tl[1][1]), .in_c10(tl[1][2]), .in_c11(tl[1][3]),
    .ready(rd1), .busy(bz1), .out(out1),
    .c00(s10), .c01(s11), .c10(s12), .c11(s13), .done(dn1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int su(input int i); return (i == 0) ? 1 : 2; endfunction
  function automatic int pu(input int i); return (i == 0) ? 2 : 1; endfunction
  function automatic int ho(input int i); return (i == 0) ? 1 : 3; endfunction
  function automatic int tp(input int i); return su(i) + pu(i) + ho(i); endfunction

  task automatic chk(input bit ok, input int inst, input string nm, input int act, input int expv);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s[%0d] @cyc %0d: got %0d expected %0d", nm, inst, cyc, act, expv);
    end
  endtask

  // Model: a tile accepted at edge A owns cycles A..A+4T-1, then done holds until the next accept.
  task automatic accept(input int i, input int a);
    int t;
    ev_t e;
    t = tp(i);
    bend[i] = a + 4 * t;
    for (int c = a; c < MAXC; c++) begin
      eb[i][c] = (c < a + 4 * t);
      ed[i][c] = (c >= a + 4 * t);
    end
    for (int k = 0; k < 4; k++) begin
      e.cyc = a + su(i) + k * t;
      e.idx = k;
      e.dat = tl[i][k];
      if (i == 0) sq0.push_back(e); else sq1.push_back(e);
    end
    if (i == 0) dq0.push_back(a + 4 * t); else dq1.push_back(a + 4 * t);
  endtask

  task automatic step();
    for (int i = 0; i < 2; i++)
      if (ld[i] && (cyc + 1 > bend[i])) accept(i, cyc + 1);
    @(posedge clk);
    #2;
  endtask

  // Monitor
  int         rise_c [2];
  int         fall_c [2];
  int         stab [2];
  bit         fall_v [2];
  logic [3:0] pst [2];
  logic       pdn [2];
  logic [7:0] pout [2];
  logic [7:0] rdat [2];

  always @(negedge clk) begin
    logic [3:0] s [2];
    logic [7:0] o [2];
    logic       b [2];
    logic       r [2];
    logic       d [2];
    ev_t        e;
    int         dc;
    bit         have;
    s[0] = {s03, s02, s01, s00}; s[1] = {s13, s12, s11, s10};
    o[0] = out0; o[1] = out1;
    b[0] = bz0;  b[1] = bz1;
    r[0] = rd0;  r[1] = rd1;
    d[0] = dn0;  d[1] = dn1;
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        pst[i] = '0; pdn[i] = 1'b0; pout[i] = '0; stab[i] = 1; fall_v[i] = 1'b0;
      end else if (cyc < MAXC) begin
        chk($countones(s[i]) <= 1, i, "onehot", int'(s[i]), 0);
        chk(b[i] == eb[i][cyc], i, "busy", int'(b[i]), int'(eb[i][cyc]));
        chk(r[i] == !eb[i][cyc], i, "ready", int'(r[i]), int'(!eb[i][cyc]));
        chk(d[i] == ed[i][cyc], i, "done", int'(d[i]), int'(ed[i][cyc]));
        if (o[i] !== pout[i]) begin
          if (fall_v[i]) chk(cyc - fall_c[i] >= ho(i), i, "hold_len", cyc - fall_c[i], ho(i));
          fall_v[i] = 1'b0;
          stab[i] = 1;
        end else begin
          stab[i]++;
        end
        if ((s[i] & ~pst[i]) != 4'b0) begin
          have = 1'b0;
          if (i == 0 && sq0.size() > 0) begin e = sq0.pop_front(); have = 1'b1; end
          if (i == 1 && sq1.size() > 0) begin e = sq1.pop_front(); have = 1'b1; end
          if (!have) begin
            chk(1'b0, i, "strobe_unexpected", int'(s[i]), 0);
          end else begin
            chk(cyc == e.cyc, i, "strobe_cycle", cyc, e.cyc);
            chk(s[i] == (4'b0001 << e.idx), i, "strobe_index", int'(s[i]), 1 << e.idx);
            chk(o[i] == e.dat, i, "strobe_data", int'(o[i]), int'(e.dat));
            chk(stab[i] >= su(i) + 1, i, "setup_len", stab[i], su(i) + 1);
          end
          rise_c[i] = cyc;
          rdat[i] = o[i];
        end
        if ((pst[i] & ~s[i]) != 4'b0) begin
          chk(cyc - rise_c[i] == pu(i), i, "pulse_width", cyc - rise_c[i], pu(i));
          chk(o[i] == rdat[i], i, "out_held", int'(o[i]), int'(rdat[i]));
          fall_c[i] = cyc;
          fall_v[i] = 1'b1;
        end
        if (d[i] && !pdn[i]) begin
          have = 1'b0;
          if (i == 0 && dq0.size() > 0) begin dc = dq0.pop_front(); have = 1'b1; end
          if (i == 1 && dq1.size() > 0) begin dc = dq1.pop_front(); have = 1'b1; end
          if (!have) chk(1'b0, i, "done_unexpected", cyc, 0);
          else chk(cyc == dc, i, "done_cycle", cyc, dc);
        end
        pst[i] = s[i]; pdn[i] = d[i]; pout[i] = o[i];
      end
    end
  end

  initial begin
    bit seen;
    rst = 1'b0;
    ld[0] = 1'b0; ld[1] = 1'b0;
    tl[0] = '0; tl[1] = '0;
    bend[0] = -1; bend[1] = -1;
    for (int c = 0; c < MAXC; c++) begin
      eb[0][c] = 1'b0; eb[1][c] = 1'b0; ed[0][c] = 1'b0; ed[1][c] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #2;
    chk(out0 == 8'h00 && out1 == 8'h00, 0, "rst_out", int'(out0), 0);
    chk({s03, s02, s01, s00, s13, s12, s11, s10} == 8'h00, 0, "rst_strobes",
        int'({s03, s02, s01, s00, s13, s12, s11, s10}), 0);
    chk(rd0 && !bz0 && !dn0, 0, "rst_ctrl", int'({rd0, bz0, dn0}), 4);
    rst = 1'b1;
    repeat (5) step();
    chk(out0 == 8'h00 && {s03, s02, s01, s00} == 4'h0, 0, "idle_after_rst", int'(out0), 0);

    // Directed: base tile, ignored load mid-sequence, back-to-back load in first done cycle
    for (int n = 0; n < 45; n++) begin
      ld[0] = 1'b0; ld[1] = 1'b0;
      if (n == 0)  begin ld[0] = 1'b1; tl[0] = {8'h44, 8'h33, 8'h22, 8'h11};
                         ld[1] = 1'b1; tl[1] = {8'hC3, 8'h3C, 8'hA5, 8'h5A}; end
      if (n == 6)  begin ld[0] = 1'b1; tl[0] = {8'hDD, 8'hCC, 8'hBB, 8'hAA}; end
      if (n == 17) begin ld[0] = 1'b1; tl[0] = {8'h04, 8'h03, 8'h02, 8'h01}; end
      if (n == 25) begin ld[1] = 1'b1; tl[1] = {8'h80, 8'h40, 8'h20, 8'h10}; end
      step();
    end

    // Reset while c10 is high
    ld[0] = 1'b1; tl[0] = {8'h9D, 8'h9C, 8'h9B, 8'h9A};
    step();
    ld[0] = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      if (s02) seen = 1'b1;
      else step();
    end
    chk(seen, 0, "c10_wait", int'(seen), 1);
    rst = 1'b0;
    #1;
    chk(!s02 && {s03, s01, s00} == 3'b000, 0, "arst_strobe", int'({s03, s02, s01, s00}), 0);
    chk(out0 == 8'h00, 0, "arst_out", int'(out0), 0);
    chk(!bz0 && rd0 && !dn0, 0, "arst_ctrl", int'({rd0, bz0, dn0}), 4);
    sq0.delete(); sq1.delete(); dq0.delete(); dq1.delete();
    for (int c = cyc; c < MAXC; c++) begin
      eb[0][c] = 1'b0; eb[1][c] = 1'b0; ed[0][c] = 1'b0; ed[1][c] = 1'b0;
    end
    bend[0] = -1; bend[1] = -1;
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst = 1'b1;
    repeat (3) step();
    chk(rd0 && !dn0, 0, "post_rst_ready", int'({rd0, dn0}), 2);

    // Random tiles and load timing
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 2; i++) begin
        ld[i] = ($urandom_range(0, 5) == 0);
        for (int k = 0; k < 4; k++) tl[i][k] = 8'($urandom);
      end
      step();
    end
    ld[0] = 1'b0; ld[1] = 1'b0;
    repeat (40) step();
    chk(sq0.size() == 0 && dq0.size() == 0, 0, "drain", sq0.size() + dq0.size(), 0);
    chk(sq1.size() == 0 && dq1.size() == 0, 1, "drain", sq1.size() + dq1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
